sram_ctrl: RTL and testbench
============================

# sram_ctrl

Sequencer between the CPU's 32-bit data port and the 16-bit asynchronous-SRAM-style data memory, which uses active-low WE/CE/OE/LB/UB and a 20-bit halfword address. It accepts one word request at a time on a valid/ready handshake. Each request is split into a high-halfword phase and a low-halfword phase. For each phase the block drives address, chip enable, byte-lane enables and strobes, and it returns read data on a single-cycle response pulse.

## Interface
Parameters:
- ADDR_W, 20, halfword address width of the memory.
- WAIT_CYC, 0, extra cycles the strobe (WE_n or OE_n) is held low in each phase; legal range 0..15.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W+1  byte address; bits [1:0] ignored (word-aligned).
- req_wdata  in  32  write data.
- req_be  in  4  byte enables; be[3] maps to bits 31:24.
- rsp_valid  out  1  one-cycle pulse when the request completes (reads and writes).
- rsp_rdata  out  32  read data; valid while rsp_valid is high; 0 for writes.
- mem_a  out  ADDR_W  halfword address.
- mem_ce_n, mem_we_n, mem_oe_n, mem_lb_n, mem_ub_n  out  1 each  active-low memory controls.
- mem_dq_o  out  16  write data to the bus.
- mem_dq_oe  out  1  1 = block drives the bus (the top level builds the tristate).
- mem_dq_i  in  16  read data from the bus.

## Operation
- Word mapping: the halfword at index 2k holds bits 31:16 and the halfword at 2k+1 holds bits 15:0, where k = req_addr[ADDR_W:2]. The high phase always runs first.
- Lanes: mem_ub_n low enables bits 15:8; mem_lb_n low enables bits 7:0.
  - High phase: ub_n = ~be[3], lb_n = ~be[2].
  - Low phase: ub_n = ~be[1], lb_n = ~be[0].
- States: IDLE, HI_ADR, HI_STB, LO_ADR, LO_STB, DONE.
- IDLE:
  - req_valid & req_ready latches we/addr/wdata/be and moves to HI_ADR.
  - Only with SRAM_CTRL_SKIP_EN: if the high phase is skipped, the block moves to LO_ADR instead (see Configuration).
- x_ADR (1 cycle): mem_a valid, ce_n=0, lanes driven, we_n=oe_n=1. For writes, mem_dq_o holds the phase halfword and mem_dq_oe=1.
- x_STB (1+WAIT_CYC cycles, counted by a 4-bit counter):
  - Writes: we_n=0; mem_dq_oe stays 1.
  - Reads: oe_n=0; mem_dq_oe=0. mem_dq_i is captured into the phase's half of the read register on the last STB cycle's edge, and disabled lanes capture 0.
- HI_STB moves to LO_ADR. LO_STB moves to DONE.
- DONE (1 cycle): rsp_valid=1, rsp_rdata = captured word; all controls are deasserted. Next state is IDLE.
- Outside the ADR and STB states: ce_n=we_n=oe_n=lb_n=ub_n=1, mem_dq_oe=0.
- Inputs are sampled only at acceptance; changes to req_* during a transaction have no effect.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, mem_a=0, all *_n=1, mem_dq_o=0, mem_dq_oe=0, state IDLE, counter 0.
- rst_n assertion at any point forces the reset values immediately (asynchronous). The in-flight request is dropped with no response; a partially written word may remain in memory.
- Latency for two phases: acceptance at edge 0, then rsp_valid is high in cycle 5+2·WAIT_CYC. With WAIT_CYC=0: ADR cycle 1, STB cycle 2, ADR cycle 3, STB cycle 4, DONE cycle 5.
- req_ready is low from cycle 1 through DONE. It returns high the cycle after DONE, so back-to-back requests are spaced 6+2·WAIT_CYC cycles apart.
- Address, lanes and write data are stable from the ADR cycle through the end of STB. we_n/oe_n never go low in an ADR cycle, so there is no strobe/address overlap at the phase boundary.

## Configuration
- SRAM_CTRL_SKIP_EN defined: a phase whose two byte enables are both 0 is skipped entirely, with no ADR or STB cycles.
  - be=4'b0011 runs only the low phase, latency 3+WAIT_CYC.
  - be=4'b0000 goes IDLE→DONE, with rsp_valid in cycle 1.
  - Skipped read halves return 0.
- SRAM_CTRL_SKIP_EN undefined: both phases always run. A disabled phase keeps both lanes high, so it is a no-op on the memory that still costs its cycles.

## Test plan
- WAIT_CYC=0: write addr 0x100C, data 0xDEADBEEF, be=1111, then read the same address. Memory index 0x806=0xDEAD and 0x807=0xBEEF; rsp_rdata=0xDEADBEEF in cycle 5; req_ready is low in cycles 1–5.
- Read with be=0100 from a word preset to 0x11223344: rsp_rdata=0x00220000.
- Byte write be=0100 with data 0xAABBCCDD over 0x11223344: memory holds 0x11BB3344 afterwards.
- WAIT_CYC=3 word read: STB lasts 4 cycles per phase and rsp_valid arrives in cycle 11.
- SRAM_CTRL_SKIP_EN with a be=0011 write: no ce_n=0 during the high phase; rsp_valid arrives in cycle 3. The same write without the macro: rsp_valid in cycle 5 and lb_n=ub_n=1 during the high phase.
- rst_n pulled low during HI_STB of a write: we_n, ce_n and mem_dq_oe go inactive without waiting for a clock edge; no rsp_valid; req_ready=1 after release; the next request completes normally.

Source files
------------

// File: rtl/sram_ctrl.sv
// sram_ctrl: sequences one 32-bit CPU word request into two 16-bit accesses
// on an asynchronous SRAM with active-low CE/WE/OE/LB/UB. The high halfword
// (index 2k) is always accessed first, then the low halfword (index 2k+1).
// Each phase has one ADR cycle, then 1+WAIT_CYC strobe cycles. A single-cycle
// DONE state returns the read word.
//
// Optional build macro: SRAM_CTRL_SKIP_EN
//   When this macro is defined, a phase whose two byte enables are both 0 is
//   skipped (no ADR or STB cycles), and the skipped half of a read returns 0.
//   When it is undefined, both phases always run. A disabled phase keeps both
//   lanes high, so it does not touch the memory.
//
// Ports:
//   clk, rst_n             clock (posedge) and async active-low reset
//   req_valid/req_ready    request handshake; ready is high only in IDLE
//   req_we, req_addr       1=write / 0=read; byte address, bits [1:0] ignored
//   req_wdata, req_be      write word; byte enables (be[3] -> bits 31:24)
//   rsp_valid, rsp_rdata   one-cycle completion pulse; read word (0 on writes)
//   mem_a                  halfword address
//   mem_ce/we/oe/lb/ub_n   active-low SRAM controls
//   mem_dq_o, mem_dq_oe    write data and bus drive enable (tristate is upstream)
//   mem_dq_i               read data from the bus
module sram_ctrl #(
  parameter int ADDR_W   = 20,
  parameter int WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W:0]   req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_ce_n,
  output logic              mem_we_n,
  output logic              mem_oe_n,
  output logic              mem_lb_n,
  output logic              mem_ub_n,
  output logic [15:0]       mem_dq_o,
  output logic              mem_dq_oe,
  input  logic [15:0]       mem_dq_i
);

  localparam int NUM_LANES = 2;  // byte lanes per halfword

  typedef enum logic [2:0] {IDLE, HI_ADR, HI_STB, LO_ADR, LO_STB, DONE} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-2:0] widx;   // word index k
    logic [31:0]       wdata;
    logic [3:0]        be;
  } req_t;

  state_t                 state_q, state_d;
  req_t                   rq;
  logic [3:0]             cnt_q;
  logic [31:0]            rdata_q;
  logic                   stb_last, in_stb, active, phase_lo;
  logic [NUM_LANES-1:0]   half_be;
  logic [15:0]            half_wd, cap_mask;
  logic                   skip_hi_in, skip_lo_in, skip_lo_q;
  logic                   unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[1:0];

`ifdef SRAM_CTRL_SKIP_EN
  assign skip_hi_in = ~|req_be[3:2];
  assign skip_lo_in = ~|req_be[1:0];
  assign skip_lo_q  = ~|rq.be[1:0];
`else
  assign skip_hi_in = 1'b0;
  assign skip_lo_in = 1'b0;
  assign skip_lo_q  = 1'b0;
`endif

  assign in_stb   = (state_q == HI_STB) || (state_q == LO_STB);
  assign active   = in_stb || (state_q == HI_ADR) || (state_q == LO_ADR);
  assign phase_lo = (state_q == LO_ADR) || (state_q == LO_STB);
  assign stb_last = (cnt_q == 4'(WAIT_CYC));
  assign half_be  = phase_lo ? rq.be[1:0] : rq.be[3:2];
  assign half_wd  = phase_lo ? rq.wdata[15:0] : rq.wdata[31:16];

  // Disabled lanes capture 0, even though the SRAM drives the full halfword.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign cap_mask[l*8 +: 8] = {8{half_be[l]}};
  end

  // State, counter, latched request and read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rq      <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_stb && !stb_last) cnt_q <= cnt_q + 4'd1;
      else                     cnt_q <= '0;
      if (state_q == IDLE && req_valid) begin
        rq.we    <= req_we;
        rq.widx  <= req_addr[ADDR_W:2];
        rq.wdata <= req_wdata;
        rq.be    <= req_be;
        rdata_q  <= '0;  // skipped halves and writes read back as 0
      end else if (in_stb && stb_last && !rq.we) begin
        if (phase_lo) rdata_q[15:0]  <= mem_dq_i & cap_mask;
        else          rdata_q[31:16] <= mem_dq_i & cap_mask;
      end
    end
  end

  // Next state and outputs. The outputs decode the registered state only, so
  // an async reset forces the bus inactive at once.
  always_comb begin
    state_d   = state_q;
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == DONE);
    rsp_rdata = (state_q == DONE) ? rdata_q : '0;
    mem_a     = '0;
    mem_ce_n  = 1'b1;
    mem_we_n  = 1'b1;
    mem_oe_n  = 1'b1;
    mem_lb_n  = 1'b1;
    mem_ub_n  = 1'b1;
    mem_dq_o  = '0;
    mem_dq_oe = 1'b0;

    unique case (state_q)
      IDLE:    if (req_valid) state_d = !skip_hi_in ? HI_ADR :
                                        !skip_lo_in ? LO_ADR : DONE;
      HI_ADR:  state_d = HI_STB;
      HI_STB:  if (stb_last) state_d = skip_lo_q ? DONE : LO_ADR;
      LO_ADR:  state_d = LO_STB;
      LO_STB:  if (stb_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (active) begin
      mem_a     = {rq.widx, phase_lo};
      mem_ce_n  = 1'b0;
      mem_ub_n  = ~half_be[1];
      mem_lb_n  = ~half_be[0];
      mem_dq_oe = rq.we;
      mem_dq_o  = rq.we ? half_wd : '0;
      // Strobes only in STB, so address never changes under a low strobe.
      mem_we_n  = ~(in_stb & rq.we);
      mem_oe_n  = ~(in_stb & ~rq.we);
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl. It runs two instances side by side: channel 0 with
// WAIT_CYC=0 and channel 1 with WAIT_CYC=3. Each channel has its own SRAM
// model. A word-level reference tracks memory contents, and the expected bus
// activity is derived per cycle from (cycle - acceptance) arithmetic.
module tb_sram_ctrl;

  localparam int WC0 = 0;
  localparam int WC1 = 3;

  logic        clk;
  logic        rst_n     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [20:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic [19:0] mem_a     [2];
  logic        ce_n [2], we_n [2], oe_n [2], lb_n [2], ub_n [2];
  logic [15:0] dq_o [2];
  logic        dq_oe [2];
  logic [15:0] dq_i [2];

  sram_ctrl #(.ADDR_W(20), .WAIT_CYC(WC0)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .mem_a(mem_a[0]),
    .mem_ce_n(ce_n[0]), .mem_we_n(we_n[0]), .mem_oe_n(oe_n[0]), .mem_lb_n(lb_n[0]),
    .mem_ub_n(ub_n[0]), .mem_dq_o(dq_o[0]), .mem_dq_oe(dq_oe[0]), .mem_dq_i(dq_i[0]));

  sram_ctrl #(.ADDR_W(20), .WAIT_CYC(WC1)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .mem_a(mem_a[1]),
    .mem_ce_n(ce_n[1]), .mem_we_n(we_n[1]), .mem_oe_n(oe_n[1]), .mem_lb_n(lb_n[1]),
    .mem_ub_n(ub_n[1]), .mem_dq_o(dq_o[1]), .mem_dq_oe(dq_oe[1]), .mem_dq_i(dq_i[1]));

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // SRAM models (halfwords) and word-level reference.
  logic [15:0] sram    [2][4096];
  logic [31:0] model_w [2][2048];
  bit          fill;

  // Current transaction per channel, as seen by the reference.
  int          t0 [2], lat [2], m_k [2];
  logic        m_we [2];
  logic [31:0] m_wd [2], m_rd [2];
  logic [3:0]  m_be [2];
  bit          run_hi [2], run_lo [2];

  // Per-transaction observations used by the literal checks.
  int          mon_c [2], mon_nrdy [2];
  logic [31:0] mon_d [2];
  bit          mon_hi_ce [2], mon_hi_lane [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  function automatic logic [31:0] seed_word(input int ch, input int k);
    return (32'(k) * 32'h9E3779B1) ^ (32'(ch) << 28) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] bemask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

  function automatic int wcyc(input int ch);
    return (ch == 0) ? WC0 : WC1;
  endfunction

  task automatic chk(input string nm, input int ch, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s ch%0d cyc=%0d got=%h expected=%h", nm, ch, cyc, got, exp);
    end
  endtask

  // SRAM behaviour: full halfword driven while CE and OE are low; enabled
  // lanes written while CE and WE are low at a clock edge.
  assign dq_i[0] = (!ce_n[0] && !oe_n[0]) ? sram[0][mem_a[0][11:0]] : 16'hFFFF;
  assign dq_i[1] = (!ce_n[1] && !oe_n[1]) ? sram[1][mem_a[1][11:0]] : 16'hFFFF;

  always @(posedge clk) begin
    if (fill) begin
      for (int ch = 0; ch < 2; ch++)
        for (int k = 0; k < 2048; k++) begin
          sram[ch][2*k]   <= seed_word(ch, k)[31:16];
          sram[ch][2*k+1] <= seed_word(ch, k)[15:0];
        end
    end else begin
      for (int ch = 0; ch < 2; ch++)
        if (!ce_n[ch] && !we_n[ch]) begin
          if (!ub_n[ch]) sram[ch][mem_a[ch][11:0]][15:8] <= dq_o[ch][15:8];
          if (!lb_n[ch]) sram[ch][mem_a[ch][11:0]][7:0]  <= dq_o[ch][7:0];
        end
    end
  end

  // Per-cycle compare against the reference schedule.
  int          cc, cw, cp, cj, ubi, lbi;
  bit          cact, cstb, cph;
  logic [41:0] c_got, c_exp, c_msk;
  always @(negedge clk) begin
    for (int ch = 0; ch < 2; ch++) if (rst_n[ch]) begin
      cc = cyc - t0[ch];
      cw = wcyc(ch);
      cact = 0; cstb = 0; cph = 0;
      if (cc >= 1 && cc < lat[ch]) begin
        cp = (cc - 1) / (2 + cw);
        cj = (cc - 1) % (2 + cw);
        cact = 1;
        cstb = (cj != 0);
        cph  = (run_hi[ch] && run_lo[ch]) ? (cp == 1) : !run_hi[ch];
      end
      c_got = {ce_n[ch], we_n[ch], oe_n[ch], ub_n[ch], lb_n[ch], dq_oe[ch], mem_a[ch], dq_o[ch]};
      if (cact) begin
        ubi = cph ? 1 : 3;
        lbi = cph ? 0 : 2;
        c_exp = {1'b0, !(m_we[ch] && cstb), !(!m_we[ch] && cstb), ~m_be[ch][ubi], ~m_be[ch][lbi],
                 m_we[ch], 20'(m_k[ch] * 2 + int'(cph)), cph ? m_wd[ch][15:0] : m_wd[ch][31:16]};
        c_msk = {6'h3F, 20'hFFFFF, m_we[ch] ? 16'hFFFF : 16'h0000};
      end else begin
        c_exp = {6'b111110, 36'h0};
        c_msk = {6'h3F, 36'h0};
      end
      chk("ctl", ch, 64'(c_got & c_msk), 64'(c_exp & c_msk));
      chk("rsp_valid", ch, 64'(rsp_valid[ch]), 64'(cc == lat[ch]));
      if (cc == lat[ch] && rsp_valid[ch]) chk("rsp_rdata", ch, 64'(rsp_rdata[ch]), 64'(m_rd[ch]));
      chk("req_ready", ch, 64'(req_ready[ch]), 64'(!(cc >= 1 && cc <= lat[ch])));
    end
  end

  // Observations, cleared in the first cycle after acceptance.
  always @(negedge clk) begin
    for (int ch = 0; ch < 2; ch++) if (rst_n[ch]) begin
      if (cyc - t0[ch] == 1) begin
        mon_c[ch] = -1; mon_d[ch] = '0; mon_nrdy[ch] = 0;
        mon_hi_ce[ch] = 0; mon_hi_lane[ch] = 0;
      end
      if (rsp_valid[ch]) begin mon_c[ch] = cyc - t0[ch]; mon_d[ch] = rsp_rdata[ch]; end
      if (!req_ready[ch]) mon_nrdy[ch]++;
      if (!ce_n[ch] && !mem_a[ch][0]) begin
        mon_hi_ce[ch] = 1;
        if (!ub_n[ch] || !lb_n[ch]) mon_hi_lane[ch] = 1;
      end
    end
  end

  // Present a request in the current cycle (caller sits at a negedge).
  task automatic start(input int ch, input logic we, input int k, input logic [31:0] wd,
                       input logic [3:0] be, input bit upd);
    logic [31:0] m;
    m = bemask(be);
    req_valid[ch] = 1; req_we[ch] = we; req_wdata[ch] = wd; req_be[ch] = be;
    req_addr[ch]  = 21'(k * 4 + int'($urandom_range(0, 3)));
    m_we[ch] = we; m_k[ch] = k; m_wd[ch] = wd; m_be[ch] = be;
`ifdef SRAM_CTRL_SKIP_EN
    run_hi[ch] = |be[3:2];
    run_lo[ch] = |be[1:0];
`else
    run_hi[ch] = 1;
    run_lo[ch] = 1;
`endif
    lat[ch]  = 1 + (int'(run_hi[ch]) + int'(run_lo[ch])) * (2 + wcyc(ch));
    m_rd[ch] = we ? 32'h0 : (model_w[ch][k] & m);
    if (we && upd) model_w[ch][k] = (model_w[ch][k] & ~m) | (wd & m);
    t0[ch] = cyc;
  endtask

  // Let the transaction run, throwing junk at the request port meanwhile.
  task automatic finish(input int ch);
    @(negedge clk);
    while (cyc <= t0[ch] + lat[ch]) begin
      req_valid[ch] = 1'($urandom_range(0, 1));
      req_we[ch]    = 1'($urandom_range(0, 1));
      req_addr[ch]  = 21'($urandom);
      req_wdata[ch] = $urandom;
      req_be[ch]    = 4'($urandom);
      @(negedge clk);
    end
    req_valid[ch] = 0;
  endtask

  task automatic req(input int ch, input logic we, input int k, input logic [31:0] wd,
                     input logic [3:0] be);
    start(ch, we, k, wd, be, 1);
    finish(ch);
  endtask

  initial begin
    clk = 0;
    fill = 1;
    for (int ch = 0; ch < 2; ch++) begin
      rst_n[ch] = 0; req_valid[ch] = 0; req_we[ch] = 0; req_addr[ch] = '0;
      req_wdata[ch] = '0; req_be[ch] = '0;
      t0[ch] = -1000; lat[ch] = 1; m_k[ch] = 0; m_we[ch] = 0; m_wd[ch] = '0;
      m_be[ch] = '0; m_rd[ch] = '0; run_hi[ch] = 1; run_lo[ch] = 1;
      for (int k = 0; k < 2048; k++) model_w[ch][k] = seed_word(ch, k);
    end
    @(posedge clk);
    #1 fill = 0;

    // Reset values.
    for (int ch = 0; ch < 2; ch++) begin
      chk("reset_ctl", ch, 64'({req_ready[ch], rsp_valid[ch], ce_n[ch], we_n[ch], oe_n[ch],
                                lb_n[ch], ub_n[ch], dq_oe[ch]}), 64'(8'b10111110));
      chk("reset_data", ch, 64'({rsp_rdata[ch], mem_a[ch], dq_o[ch]}), 64'h0);
    end
    @(negedge clk);
    #2 rst_n[0] = 1; rst_n[1] = 1;
    @(negedge clk);

    // Word write, then read back (WAIT_CYC=0).
    req(0, 1, 32'h100C >> 2, 32'hDEADBEEF, 4'hF);
    chk("wr_hi_half", 0, 64'(sram[0][12'h806]), 64'h DEAD);
    chk("wr_lo_half", 0, 64'(sram[0][12'h807]), 64'h BEEF);
    req(0, 0, 32'h100C >> 2, 32'h0, 4'hF);
    chk("rd_latency", 0, 64'(mon_c[0]), 64'd5);
    chk("rd_data", 0, 64'(mon_d[0]), 64'h DEADBEEF);
    chk("rd_busy_cycles", 0, 64'(mon_nrdy[0]), 64'd5);

    // Byte-lane read and write over a preset word.
    req(0, 1, 32'h80, 32'h11223344, 4'hF);
    req(0, 0, 32'h80, 32'h0, 4'b0100);
    chk("rd_be0100", 0, 64'(mon_d[0]), 64'h00220000);
    req(0, 1, 32'h80, 32'hAABBCCDD, 4'b0100);
    chk("wr_be0100", 0, 64'({sram[0][12'h100], sram[0][12'h101]}), 64'h11BB3344);

    // WAIT_CYC=3 word read.
    req(1, 0, 32'h403, 32'h0, 4'hF);
    chk("wait3_latency", 1, 64'(mon_c[1]), 64'd11);
    chk("wait3_busy", 1, 64'(mon_nrdy[1]), 64'd11);

    // Low-only write: the high phase never enables a lane.
    req(0, 1, 7, 32'h12345678, 4'b0011);
    chk("lo_only_hi_lanes", 0, 64'(mon_hi_lane[0]), 64'd0);
`ifdef SRAM_CTRL_SKIP_EN
    chk("lo_only_latency", 0, 64'(mon_c[0]), 64'd3);
    chk("lo_only_hi_ce", 0, 64'(mon_hi_ce[0]), 64'd0);
    req(0, 0, 9, 32'h0, 4'b0000);
    chk("no_lane_latency", 0, 64'(mon_c[0]), 64'd1);
`else
    chk("lo_only_latency", 0, 64'(mon_c[0]), 64'd5);
`endif

    // Reset during HI_STB of a write.
    start(0, 1, 5, 32'hCAFEF00D, 4'hF, 0);
    @(negedge clk);              // HI_ADR
    req_valid[0] = 0;
    @(negedge clk);              // HI_STB
    #2 rst_n[0] = 0;
    #1;
    chk("async_rst_ctl", 0, 64'({we_n[0], ce_n[0], dq_oe[0], rsp_valid[0]}), 64'(4'b1100));
    t0[0] = -1000;
    @(negedge clk);
    #2 rst_n[0] = 1;
    @(negedge clk);
    chk("rst_ready", 0, 64'(req_ready[0]), 64'd1);
    req(0, 0, 5, 32'h0, 4'hF);
    chk("after_rst_latency", 0, 64'(mon_c[0]), 64'd5);

    // Randomized traffic, with mostly back-to-back requests on a few hot words.
    for (int ch = 0; ch < 2; ch++)
      for (int n = 0; n < (ch == 0 ? 150 : 60); n++) begin
        int k;
        logic [3:0] be;
        k  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 15));
        be = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
        req(ch, 1'($urandom_range(0, 1)), k, $urandom, be);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
      end

    // End-to-end memory contents.
    for (int ch = 0; ch < 2; ch++) begin
      int nbad = 0;
      for (int k = 0; k < 2048; k++)
        if ({sram[ch][2*k], sram[ch][2*k+1]} !== model_w[ch][k]) begin
          if (nbad == 0)
            $display("FAIL mem_contents ch%0d word %0d got=%h expected=%h",
                     ch, k, {sram[ch][2*k], sram[ch][2*k+1]}, model_w[ch][k]);
          nbad++;
        end
      checks++;
      if (nbad != 0) errors++;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
